// File: rtl/cache_pkg.sv
// Shared cache-side constants: memory-arbiter state encodings and requester IDs.
// Used by the memory arbiter and by both cache controllers.
package cache_pkg;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StGrant0  = 2'd1;
    localparam logic [1:0] StGrant1  = 2'd2;
    localparam logic [1:0] StRelease = 2'd3;

    localparam logic ReqIcache = 1'b0;
    localparam logic ReqDcache = 1'b1;

    function automatic logic [1:0] grant_state(input logic req_id);
        return (req_id == ReqDcache) ? StGrant1 : StGrant0;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Requester and data-memory signals of the cache memory arbiter.
// master = arbiter side, slave = requesters plus memory.
interface cache_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
);
    logic              rq0_enable_i;
    logic              rq1_enable_i;
    logic              rq0_write_i;
    logic              rq1_write_i;
    logic [ADDR_W-1:0] rq0_addr_i;
    logic [ADDR_W-1:0] rq1_addr_i;
    logic [DATA_W-1:0] rq0_data_i;
    logic [DATA_W-1:0] rq1_data_i;
    logic              rq0_ack_o;
    logic              rq1_ack_o;
    logic [DATA_W-1:0] rq_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              busy_o;
    logic              err_o;

    modport master (
        input  rq0_enable_i, rq1_enable_i, rq0_write_i, rq1_write_i,
        input  rq0_addr_i, rq1_addr_i, rq0_data_i, rq1_data_i,
        input  mem_data_i, mem_ack_i,
        output rq0_ack_o, rq1_ack_o, rq_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output busy_o, err_o
    );

    modport slave (
        output rq0_enable_i, rq1_enable_i, rq0_write_i, rq1_write_i,
        output rq0_addr_i, rq1_addr_i, rq0_data_i, rq1_data_i,
        output mem_data_i, mem_ack_i,
        input  rq0_ack_o, rq1_ack_o, rq_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  busy_o, err_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, last winner
// recorded only when update_i is high.
module rr_arb2
    import cache_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie goes to whoever did not win last time.
            2'b11:   gnt_o = (last_q == ReqDcache) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= ReqDcache;
        end else if (update_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one data-memory port, with round-robin
// tie-break, a one-cycle release gap between grants and a sticky grant timeout.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 256,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input logic                 clk_i,
    input logic                 rst_i,
    cache_mem_arbiter_if.master bus
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [1:0]        rr_gnt;
    logic              rr_update;
    logic              in_grant;
    logic              timeout;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] data_mux;

    rr_arb2 u_rr_arb2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({bus.rq1_enable_i, bus.rq0_enable_i}),
        .update_i (rr_update),
        .gnt_o    (rr_gnt)
    );

    assign in_grant  = (state_q == StGrant0) || (state_q == StGrant1);
    assign rr_update = (state_q == StIdle);
    // The counter would reach TIMEOUT_CYC at the end of this grant cycle.
    assign timeout   = in_grant && !bus.mem_ack_i && (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (rr_gnt != 2'b00) begin
                    state_d = grant_state(rr_gnt[1]);
                    cnt_d   = '0;
                end
            end
            StGrant0, StGrant1: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (bus.mem_ack_i) begin
                    state_d = StRelease;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        addr_mux = '0;
        data_mux = '0;
        if (state_q == StGrant0) begin
            mem_en   = 1'b1;
            mem_wr   = bus.rq0_write_i;
            addr_mux = bus.rq0_addr_i;
            data_mux = bus.rq0_data_i;
        end else if (state_q == StGrant1) begin
            mem_en   = 1'b1;
            mem_wr   = bus.rq1_write_i;
            addr_mux = bus.rq1_addr_i;
            data_mux = bus.rq1_data_i;
        end
    end

    assign bus.mem_enable_o = mem_en;
    assign bus.mem_write_o  = mem_wr;
    assign bus.mem_addr_o   = addr_mux;
    assign bus.mem_data_o   = data_mux;
    assign bus.rq0_ack_o    = bus.mem_ack_i && (state_q == StGrant0);
    assign bus.rq1_ack_o    = bus.mem_ack_i && (state_q == StGrant1);
    assign bus.rq_data_o    = bus.mem_data_i;
    assign bus.busy_o       = (state_q != StIdle);
    assign bus.err_o        = err_q;

endmodule
